xor_stream_arbiter: RTL and testbench
=====================================

Name: xor_stream_arbiter

Overview:
- Shares one XOR cipher datapath between two byte-stream requesters (ch0, ch1) using round-robin arbitration.
- Each channel owns an 8-bit keystream register: seeded from a parameter, reloadable through a config port, advanced by a Galois LFSR step after every accepted byte.
- Output is one registered byte with valid/ready handshake and a channel tag.
- Sits between the pin-level byte inputs and the output bus of the XOR encryption tile.

Parameters:
- KEY0, 8'hBE, reset seed of the ch0 keystream register
- KEY1, 8'hCA, reset seed of the ch1 keystream register
- POLY, 8'hB8, Galois LFSR feedback mask

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  key write strobe
- cfg_ch  in  1  channel selected by the key write
- cfg_key  in  8  new keystream value
- s0_valid  in  1  ch0 byte valid
- s0_data  in  8  ch0 plaintext or ciphertext byte
- s0_ready  out  1  ch0 byte accepted this cycle
- s1_valid  in  1  ch1 byte valid
- s1_data  in  8  ch1 byte
- s1_ready  out  1  ch1 byte accepted this cycle
- m_valid  out  1  output byte valid
- m_data  out  8  s_data XOR keystream
- m_ch  out  1  channel that produced m_data
- m_ready  in  1  downstream accepts the output byte

Behaviour:
- Reset (rst=1 at a clk edge):
  - ks0=KEY0, ks1=KEY1.
  - m_valid=0, m_data=0, m_ch=0.
  - last=1, so ch0 has priority first.
  - Reset overrides every other event in that cycle.
- space = !m_valid | m_ready.
- Grant (combinational):
  - Only one valid: that channel is granted if space=1.
  - Both valid: channel !last is granted if space=1.
  - No space: nothing is granted.
  - sX_ready = grant to X. At most one sX_ready is high per cycle. sX_ready may depend on sX_valid.
- Accept (sX_valid & sX_ready) at a clk edge:
  - m_data <= sX_data ^ ksX, using the key value before the update.
  - m_ch <= X, m_valid <= 1, last <= X.
  - ksX <= step(ksX).
- step(k) = {1'b0, k[7:1]} ^ (k[0] ? POLY : 8'h00).
  - Key 0 is a fixed point: the channel then passes data through unchanged. This is legal.
- Drain: m_valid & m_ready with no accept -> m_valid <= 0. m_data and m_ch hold their last values.
- Full throughput: accept and drain in the same cycle gives one byte per cycle. Latency is 1 cycle from accept to m_valid.
- Backpressure: while m_valid=1 and m_ready=0:
  - m_data and m_ch stay stable.
  - Both sX_ready are 0.
  - No keystream advances.
- Config write: cfg_we=1 loads ks[cfg_ch] <= cfg_key.
  - If it targets the channel accepting in the same cycle, the config write wins over the LFSR advance.
  - The byte accepted in that cycle still uses the old key.
  - A write to the other channel does not disturb the accept.
- The non-granted channel's keystream is never advanced.
- Decryption uses the same block with the same seed and byte order. XOR is self-inverse.

Test Plan:
- Reset, then ch0 sends 0x00,0x00,0x00 with m_ready=1 -> m_data 0xBE, 0x5F, 0x97; m_ch=0; one byte per cycle; m_valid the cycle after each accept.
- Reset, then ch1 sends 0x41 -> m_data=0x8B, m_ch=1; ks0 unchanged (next ch0 0x00 -> 0xBE).
- Reset, both channels valid for 4 cycles with m_ready=1 -> grant order ch0, ch1, ch0, ch1; outputs 0xBE, 0xCA, then ch0 0x5F.
- m_ready=0 for 3 cycles with a byte pending -> m_data/m_ch stable, s0_ready=s1_ready=0, keys frozen; on m_ready=1 the queued byte is accepted the same cycle.
- cfg_we=1, cfg_ch=0, cfg_key=0x01 in the same cycle ch0 accepts 0x00 -> that output is 0xBE; next ch0 0x00 -> 0x01; cfg_key=0x00 -> passthrough 0x5A -> 0x5A.
- Reset asserted while m_valid=1 and both channels streaming -> next cycle m_valid=0 and all ready signals low; after release ch0 0x00 -> 0xBE again.

Source files
------------

// File: rtl/xor_stream_arbiter.sv
// Round-robin share of one XOR cipher datapath between two byte streams.
// Each channel keeps its own Galois-LFSR keystream; output is a registered byte with a channel tag.
module xor_stream_arbiter #(
  parameter logic [7:0] KEY0 = 8'hBE,
  parameter logic [7:0] KEY1 = 8'hCA,
  parameter logic [7:0] POLY = 8'hB8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic       cfg_ch,
  input  logic [7:0] cfg_key,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  output logic       s1_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_ch,
  input  logic       m_ready
);

  function automatic logic [7:0] lfsr_step(input logic [7:0] k);
    return {1'b0, k[7:1]} ^ (k[0] ? POLY : 8'h00);
  endfunction

  logic [7:0] ks0_q, ks0_d;
  logic [7:0] ks1_q, ks1_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_ch_q, m_ch_d;
  logic       last_q, last_d;

  logic space;
  logic gnt0, gnt1;

  // Grants are masked during reset so nothing is accepted in a reset cycle.
  always_comb begin
    space = !m_valid_q || m_ready;
    gnt0  = !rst && space && s0_valid && (!s1_valid || last_q);
    gnt1  = !rst && space && s1_valid && (!s0_valid || !last_q);
  end

  always_comb begin
    ks0_d     = ks0_q;
    ks1_d     = ks1_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ch_d    = m_ch_q;
    last_d    = last_q;

    if (gnt0) begin
      m_data_d  = s0_data ^ ks0_q;
      m_ch_d    = 1'b0;
      m_valid_d = 1'b1;
      last_d    = 1'b0;
      ks0_d     = lfsr_step(ks0_q);
    end else if (gnt1) begin
      m_data_d  = s1_data ^ ks1_q;
      m_ch_d    = 1'b1;
      m_valid_d = 1'b1;
      last_d    = 1'b1;
      ks1_d     = lfsr_step(ks1_q);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    // A key write overrides the LFSR advance of the same cycle.
    if (cfg_we) begin
      if (cfg_ch) begin
        ks1_d = cfg_key;
      end else begin
        ks0_d = cfg_key;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ks0_q     <= KEY0;
      ks1_q     <= KEY1;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_ch_q    <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      ks0_q     <= ks0_d;
      ks1_q     <= ks1_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ch_q    <= m_ch_d;
      last_q    <= last_d;
    end
  end

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_ch     = m_ch_q;

endmodule

// File: tb/tb_xor_stream_arbiter.sv
// Directed bench for xor_stream_arbiter; expected bytes are hand-computed from the LFSR.
module tb_xor_stream_arbiter;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic       cfg_ch;
  logic [7:0] cfg_key;
  logic       s0_valid;
  logic [7:0] s0_data;
  logic       s0_ready;
  logic       s1_valid;
  logic [7:0] s1_data;
  logic       s1_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ch;
  logic       m_ready;

  int n_cmp;
  int n_err;

  xor_stream_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_key  (cfg_key),
    .s0_valid (s0_valid),
    .s0_data  (s0_data),
    .s0_ready (s0_ready),
    .s1_valid (s1_valid),
    .s1_data  (s1_data),
    .s1_ready (s1_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ch     (m_ch),
    .m_ready  (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    cfg_we   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    cfg_we   = 1'b0;
    cfg_ch   = 1'b0;
    cfg_key  = 8'h00;
    s0_valid = 1'b0;
    s0_data  = 8'h00;
    s1_valid = 1'b0;
    s1_data  = 8'h00;
    m_ready  = 1'b1;

    // Reset state and ch0 keystream sequence
    do_reset();
    check("rst_m_valid", {7'd0, m_valid}, 8'h00);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_ch", {7'd0, m_ch}, 8'h00);
    s0_valid = 1'b1;
    s0_data  = 8'h00;
    #1;
    check("t1_s0_ready", {7'd0, s0_ready}, 8'h01);
    tick();
    check("t1_valid0", {7'd0, m_valid}, 8'h01);
    check("t1_data0", m_data, 8'hBE);
    check("t1_ch0", {7'd0, m_ch}, 8'h00);
    tick();
    check("t1_data1", m_data, 8'h5F);
    tick();
    check("t1_data2", m_data, 8'h97);
    s0_valid = 1'b0;
    tick();
    check("t1_drain_valid", {7'd0, m_valid}, 8'h00);
    check("t1_drain_hold", m_data, 8'h97);

    // ch1 alone; ch0 key untouched
    do_reset();
    s1_valid = 1'b1;
    s1_data  = 8'h41;
    tick();
    check("t2_ch1_data", m_data, 8'h8B);
    check("t2_ch1_tag", {7'd0, m_ch}, 8'h01);
    s1_valid = 1'b0;
    s0_valid = 1'b1;
    s0_data  = 8'h00;
    tick();
    check("t2_ch0_data", m_data, 8'hBE);
    s0_valid = 1'b0;
    tick();

    // Round-robin with both valid
    do_reset();
    s0_valid = 1'b1;
    s0_data  = 8'h00;
    s1_valid = 1'b1;
    s1_data  = 8'h00;
    #1;
    check("t3_first_s0_ready", {7'd0, s0_ready}, 8'h01);
    check("t3_first_s1_ready", {7'd0, s1_ready}, 8'h00);
    tick();
    check("t3_g0_data", m_data, 8'hBE);
    check("t3_g0_ch", {7'd0, m_ch}, 8'h00);
    check("t3_g1_s1_ready", {7'd0, s1_ready}, 8'h01);
    tick();
    check("t3_g1_data", m_data, 8'hCA);
    check("t3_g1_ch", {7'd0, m_ch}, 8'h01);
    tick();
    check("t3_g2_data", m_data, 8'h5F);
    check("t3_g2_ch", {7'd0, m_ch}, 8'h00);
    tick();
    check("t3_g3_data", m_data, 8'h65);
    check("t3_g3_ch", {7'd0, m_ch}, 8'h01);
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    tick();

    // Backpressure freezes output and keys
    do_reset();
    m_ready  = 1'b0;
    s0_valid = 1'b1;
    s0_data  = 8'h00;
    tick();
    check("t4_first", m_data, 8'hBE);
    s1_valid = 1'b1;
    s1_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_s0_ready", {7'd0, s0_ready}, 8'h00);
      check("t4_stall_s1_ready", {7'd0, s1_ready}, 8'h00);
      check("t4_stall_valid", {7'd0, m_valid}, 8'h01);
      check("t4_stall_data", m_data, 8'hBE);
      check("t4_stall_ch", {7'd0, m_ch}, 8'h00);
      tick();
    end
    m_ready = 1'b1;
    #1;
    check("t4_release_s1_ready", {7'd0, s1_ready}, 8'h01);
    tick();
    check("t4_release_data", m_data, 8'hCA);
    check("t4_release_ch", {7'd0, m_ch}, 8'h01);
    s1_valid = 1'b0;
    tick();
    check("t4_ch0_key_frozen", m_data, 8'h5F);
    s0_valid = 1'b0;
    tick();

    // Config write collides with accept on the same channel
    do_reset();
    s0_valid = 1'b1;
    s0_data  = 8'h00;
    cfg_we   = 1'b1;
    cfg_ch   = 1'b0;
    cfg_key  = 8'h01;
    tick();
    check("t5_old_key", m_data, 8'hBE);
    cfg_we = 1'b0;
    tick();
    check("t5_new_key", m_data, 8'h01);
    s0_valid = 1'b0;
    cfg_we   = 1'b1;
    cfg_key  = 8'h00;
    tick();
    cfg_we   = 1'b0;
    s0_valid = 1'b1;
    s0_data  = 8'h5A;
    tick();
    check("t5_pass0", m_data, 8'h5A);
    tick();
    check("t5_pass1", m_data, 8'h5A);
    // A write to ch1 during a ch0 accept leaves ch0 alone
    s0_data = 8'h33;
    cfg_we  = 1'b1;
    cfg_ch  = 1'b1;
    cfg_key = 8'h0F;
    tick();
    check("t5_other_ch_write", m_data, 8'h33);
    cfg_we   = 1'b0;
    s0_valid = 1'b0;
    s1_valid = 1'b1;
    s1_data  = 8'h00;
    tick();
    check("t5_ch1_new_key", m_data, 8'h0F);
    s1_valid = 1'b0;
    tick();

    // Reset mid-stream
    do_reset();
    s0_valid = 1'b1;
    s0_data  = 8'h00;
    s1_valid = 1'b1;
    s1_data  = 8'h00;
    tick();
    tick();
    check("t6_pre_valid", {7'd0, m_valid}, 8'h01);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", {7'd0, m_valid}, 8'h00);
    check("t6_rst_s0_ready", {7'd0, s0_ready}, 8'h00);
    check("t6_rst_s1_ready", {7'd0, s1_ready}, 8'h00);
    check("t6_rst_data", m_data, 8'h00);
    rst      = 1'b0;
    s1_valid = 1'b0;
    tick();
    check("t6_after_data", m_data, 8'hBE);
    check("t6_after_ch", {7'd0, m_ch}, 8'h00);
    s0_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
